retire_trace_buffer: RTL
========================

RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entry count; power of two, at least 4.
REQ-002 SHALL have ports clk (input, 1): single clock, all state updates on its rising edge.
REQ-003 SHALL have port reset (input, 1): synchronous, active-high; sampled only at rising clk.
REQ-004 SHALL have ports retire_valid_a/retire_valid_b (input, 1 each): lane A/B retires this cycle.
REQ-005 SHALL have ports retire_pc_a/_b and retire_inst_a/_b (input, 32 each): PC and instruction word.
REQ-006 SHALL have ports retire_reg_addr_a/_b (input, 5 each): destination register.
REQ-007 SHALL have ports retire_reg_data_a/_b (input, 32 each): writeback value.
REQ-008 SHALL have ports retire_mem_addr_a/_b and retire_mem_data_a/_b (input, 32 each): memory address and data.
REQ-009 SHALL have ports retire_mem_wrt_a/_b (input, 1 each): lane performed a store.
REQ-010 SHALL have port trace_valid (output, 1): head entry available.
REQ-011 SHALL have port trace_ready (input, 1): consumer accepts head this cycle.
REQ-012 SHALL have ports trace_pc, trace_inst, trace_reg_data, trace_mem_addr, trace_mem_data (output, 32 each): head entry fields.
REQ-013 SHALL have ports trace_reg_addr (output, 5) and trace_mem_wrt (output, 1): head entry fields.
REQ-014 SHALL have port count (output, $clog2(DEPTH)+1): entries currently stored.
REQ-015 SHALL have port almost_full (output, 1): high when DEPTH-count < 2.
REQ-016 SHALL have port overflow (output, 1): sticky flag, a retirement was dropped.
REQ-017 SHALL have port instret (output, 64): total valid retirements seen, including dropped ones.

Function
REQ-018 SHALL implement a circular FIFO with read/write pointers of width $clog2(DEPTH) that wrap from DEPTH-1 to 0.
REQ-019 SHALL push 0, 1 or 2 entries per cycle; lane A is always written before lane B (program order).
REQ-020 SHALL push lane B alone into the next free slot when retire_valid_b=1 and retire_valid_a=0.
REQ-021 SHALL compute free space from registered count only; a pop in the same cycle does not create push space.
REQ-022 SHALL accept lane A if free>=1; accept lane B if free>=1 (A not valid) or free>=2 (A valid).
REQ-023 SHALL drop any valid lane that does not fit; a drop sets overflow=1 next cycle.
REQ-024 SHALL pop the head when trace_valid && trace_ready; trace_valid = (count!=0); outputs driven combinationally from the head entry.
REQ-025 SHALL update count as count + pushes - pop, with range 0..DEPTH; a simultaneous push and pop at full with no push space leaves count = DEPTH-1.
REQ-026 SHALL hold head fields stable while trace_valid && !trace_ready.
REQ-027 SHALL add (retire_valid_a + retire_valid_b) to instret every cycle, wrapping modulo 2^64.
REQ-028 SHALL clear overflow only by reset.

Reset
REQ-029 SHALL, on reset=1 at a rising edge: set pointers, count, instret and overflow to 0, drive trace_valid=0, and ignore same-cycle retire inputs (no push, no instret increment).
REQ-030 SHALL, on reset mid-operation, discard all stored entries; trace_* data outputs are don't-care while trace_valid=0.

Verification
REQ-031 SHALL verify dual push: A pc=0x100, B pc=0x104 with trace_ready=0, then ready=1 -> count=2, outputs 0x100 then 0x104 on consecutive cycles, instret=2.
REQ-032 SHALL verify B-only push: valid_b=1 pc=0x200, valid_a=0 -> single entry 0x200, count=1.
REQ-033 SHALL verify fill: DEPTH=8, count=7, dual retire -> A stored, B dropped, count=8, overflow=1, almost_full=1, instret increments by 2.
REQ-034 SHALL verify full with push and pop: count=8, trace_ready=1, single retire -> retire dropped, count=7, overflow=1.
REQ-035 SHALL verify wrap: 20 single pushes interleaved with pops -> FIFO order preserved across pointer wrap, no overflow.
REQ-036 SHALL verify reset: reset pulse at count=5 -> next cycle count=0, trace_valid=0, overflow=0, instret=0.

Source files
------------

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: dual-lane retirement trace FIFO with drop flag and instret counter
module retire_trace_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     retire_valid_a,
  input  logic                     retire_valid_b,
  input  logic [31:0]              retire_pc_a,
  input  logic [31:0]              retire_pc_b,
  input  logic [31:0]              retire_inst_a,
  input  logic [31:0]              retire_inst_b,
  input  logic [4:0]               retire_reg_addr_a,
  input  logic [4:0]               retire_reg_addr_b,
  input  logic [31:0]              retire_reg_data_a,
  input  logic [31:0]              retire_reg_data_b,
  input  logic [31:0]              retire_mem_addr_a,
  input  logic [31:0]              retire_mem_addr_b,
  input  logic [31:0]              retire_mem_data_a,
  input  logic [31:0]              retire_mem_data_b,
  input  logic                     retire_mem_wrt_a,
  input  logic                     retire_mem_wrt_b,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [31:0]              trace_pc,
  output logic [31:0]              trace_inst,
  output logic [31:0]              trace_reg_data,
  output logic [31:0]              trace_mem_addr,
  output logic [31:0]              trace_mem_data,
  output logic [4:0]               trace_reg_addr,
  output logic                     trace_mem_wrt,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [63:0]              instret
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 166;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, wr_ptr_b;
  logic [CW-1:0] free;
  logic [EW-1:0] ent_a, ent_b;
  logic acc_a, acc_b, pop, drop;
  assign ent_a = {retire_pc_a, retire_inst_a, retire_reg_addr_a, retire_reg_data_a, retire_mem_addr_a, retire_mem_data_a, retire_mem_wrt_a};
  assign ent_b = {retire_pc_b, retire_inst_b, retire_reg_addr_b, retire_reg_data_b, retire_mem_addr_b, retire_mem_data_b, retire_mem_wrt_b};
  assign {trace_pc, trace_inst, trace_reg_addr, trace_reg_data, trace_mem_addr, trace_mem_data, trace_mem_wrt} = mem[rd_ptr];
  always_comb begin
    free = CW'(DEPTH) - count;
    acc_a = retire_valid_a && free != '0;
    acc_b = retire_valid_b && (retire_valid_a ? free > CW'(1) : free != '0);
    drop = (retire_valid_a && !acc_a) || (retire_valid_b && !acc_b);
    trace_valid = count != '0;
    pop = trace_valid && trace_ready;
    almost_full = free < CW'(2);
    wr_ptr_b = wr_ptr + AW'(acc_a);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      instret <= '0;
      overflow <= 1'b0;
    end else begin
      if (acc_a) mem[wr_ptr] <= ent_a;
      if (acc_b) mem[wr_ptr_b] <= ent_b;
      wr_ptr <= wr_ptr + AW'(acc_a) + AW'(acc_b);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(acc_a) + CW'(acc_b) - CW'(pop);
      instret <= instret + 64'(retire_valid_a) + 64'(retire_valid_b);
      overflow <= overflow | drop;
    end
  end
endmodule
